pipeline_reg_chain: RTL
=======================

Name: pipeline_reg_chain

Overview:
- Parametrised elastic pipeline-register chain; next generation of the fixed ifid/idex/exmem/memwb registers.
- Carries a payload plus destination-register tag through DEPTH stages.
- Supports per-stage valid bits, valid/ready backpressure (stall), global flush and an occupancy count.
- Sits between any two pipeline stages of the core and replaces hand-written block/stall wiring.

Parameters:
- WIDTH, 32: payload width in bits (matches COMMON_WIDTH).
- TAG_W, 5: destination-register tag width (matches REG_NUM).
- DEPTH, 2: number of register stages, 1..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; invalidates every stage.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  chain accepts an entry this cycle.
- in_data  input  WIDTH  payload.
- in_tag  input  TAG_W  destination register; 0 = no write.
- out_valid  output  1  stage DEPTH-1 holds a valid entry.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- out_tag  output  TAG_W  tag of stage DEPTH-1.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.
- fwd_tag  input  TAG_W  forwarding query (PIPE_FWD_EN only).
- fwd_hit  output  1  query matched (PIPE_FWD_EN only).
- fwd_data  output  WIDTH  forwarded payload (PIPE_FWD_EN only).

Behaviour:
- Reset (rst=0, async): all stage valid bits cleared; data and tag registers cleared to 0.
  - Outputs during reset: out_valid=0, out_data=0, out_tag=0, occupancy=0, fwd_hit=0, fwd_data=0.
  - in_ready=1 as soon as rst is deasserted.
- Stage index: 0 is the input side, DEPTH-1 is the output.
- Advance rule:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
  - in_ready = adv[0].
  - Ready propagates combinationally (full-throughput chain, no bubbles).
- On a clock edge where adv[i]=1:
  - Stage i loads from stage i-1 (valid, data, tag).
  - Stage 0 loads in_valid/in_data/in_tag.
  - When the source stage is invalid, the stage becomes invalid; its data and tag may hold.
- Latency: an entry accepted at edge N appears on out_* after edge N+DEPTH-1 (visible DEPTH-1 cycles after acceptance); DEPTH=1 gives 1 register.
- Throughput: 1 entry/cycle while out_ready=1.
- Stall: out_ready=0 with the chain full drives in_ready=0; all stages hold their contents bit-exact.
- Bubble collapse: an invalid stage accepts a new entry even when downstream is stalled.
- Flush:
  - On the edge where flush=1, every valid bit clears.
  - The in_valid entry offered that cycle is dropped, even if in_ready=1.
  - occupancy=0 on the next cycle.
  - in_ready is unaffected by flush within the cycle.
- out_valid & out_ready & flush in the same cycle: the output entry counts as consumed; the downstream sees the handshake.
- occupancy: registered population count of the valid bits, updated each edge; never exceeds DEPTH.
- Tag 0 passes through unchanged and carries no special semantics inside the chain.
- Reset asserted mid-stall: the chain empties immediately, asynchronously.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined:
  - Combinational forwarding lookup.
  - fwd_hit=1 when some valid stage has tag==fwd_tag and fwd_tag!=0.
  - fwd_data = payload of the matching stage closest to the input (youngest, lowest index).
  - With no match: fwd_hit=0, fwd_data=0.
- Undefined:
  - fwd_tag is ignored.
  - fwd_hit and fwd_data are tied to 0.
  - No comparator logic is generated.

Test Plan:
- DEPTH=2, stream data 1..4 with tags 1..4, out_ready=1 -> out_data 1..4 on consecutive cycles; first out_valid 1 cycle after first accept; occupancy settles at 2.
- Fill a DEPTH=3 chain with 0xA/0xB/0xC, hold out_ready=0 for 5 cycles -> in_ready=0, out_data stays 0xA, occupancy=3; release -> 0xA, 0xB, 0xC drain in order with no loss.
- Only stage 0 valid, out_ready=0, in_valid=1 with 0xD -> accepted (in_ready=1); chain holds 2 entries, no overwrite.
- Chain full, flush=1 with in_valid=1 and data 0xE -> next cycle out_valid=0, occupancy=0; 0xE never appears.
- Assert rst=0 mid-stream between clock edges -> out_valid, occupancy and out_data drop to 0 without a clock edge; after release the first new entry passes correctly.
- PIPE_FWD_EN, DEPTH=3, stages hold tag 5 (0x11, stage 2) and tag 5 (0x22, stage 0):
  - fwd_tag=5 -> fwd_hit=1, fwd_data=0x22.
  - fwd_tag=0 -> fwd_hit=0.
  - fwd_tag=7 -> fwd_hit=0, fwd_data=0.

Source files
------------

// File: rtl/pipeline_reg_chain.sv
// pipeline_reg_chain -- parametrised elastic register chain with valid/ready
// backpressure, global flush and occupancy count. Stage 0 is the input side,
// stage DEPTH-1 drives out_*.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   flush               synchronous invalidate of every stage (input entry dropped)
//   in_valid/in_ready   upstream handshake; in_data/in_tag = payload and dest reg
//   out_valid/out_ready downstream handshake; out_data/out_tag from last stage
//   occupancy           number of valid stages
//   fwd_tag/fwd_hit/fwd_data  forwarding lookup (youngest matching stage)
//
// Optional feature macro: PIPE_FWD_EN. When undefined, fwd_tag is ignored and
// fwd_hit/fwd_data are tied to zero with no comparators built.

module pipeline_reg_stage #(
  parameter int ENT_W = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             src_valid,
  input  logic [ENT_W-1:0] src_ent,
  output logic             valid,
  output logic [ENT_W-1:0] ent
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ent   <= '0;
    end else begin
      if (flush)    valid <= 1'b0;
      else if (adv) valid <= src_valid;
      // Payload only moves with a live entry; an invalidated stage keeps stale bits.
      if (adv && src_valid && !flush) ent <= src_ent;
    end
  end
endmodule

module pipeline_reg_chain #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [OCC_W-1:0] occupancy,
  input  logic [TAG_W-1:0] fwd_tag,
  output logic             fwd_hit,
  output logic [WIDTH-1:0] fwd_data
);
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam int ENT_W = WIDTH + TAG_W;

  // Index 0 is the upstream source; index i+1 is the output of stage i.
  logic   [DEPTH:0] vld_pipe;
  entry_t [DEPTH:0] ent_pipe;
  logic   [DEPTH-1:0] adv;

  assign vld_pipe[0] = in_valid;
  assign ent_pipe[0] = '{tag: in_tag, data: in_data};

  // Stage i may advance if any stage from i to the output is empty or the
  // output is being consumed. Written flat rather than as a ripple so the
  // ready path has no self-referencing vector.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic full;
      full = 1'b1;
      for (int j = i; j < DEPTH; j++) full = full & vld_pipe[j+1];
      adv[i] = !full || out_ready;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    pipeline_reg_stage #(.ENT_W(ENT_W)) u_stg (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .adv       (adv[g]),
      .src_valid (vld_pipe[g]),
      .src_ent   (ent_pipe[g]),
      .valid     (vld_pipe[g+1]),
      .ent       (ent_pipe[g+1])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_pipe[DEPTH];
  assign out_data  = ent_pipe[DEPTH].data;
  assign out_tag   = ent_pipe[DEPTH].tag;

  // Population count of the stage valid flops.
  always_comb begin
    occupancy = '0;
    for (int i = 1; i <= DEPTH; i++) occupancy = occupancy + OCC_W'(vld_pipe[i]);
  end

`ifdef PIPE_FWD_EN
  // Scan output-to-input so the youngest (lowest index) match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (vld_pipe[i+1] && (ent_pipe[i+1].tag == fwd_tag) && (fwd_tag != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_pipe[i+1].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_tag;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
